// File: rtl/dh_pkg.sv
// dh_pkg: shared types and constants for the Diffie-Hellman responder
package dh_pkg;
  localparam int DEF_W = 32;
  localparam int ONE = 1;
  typedef enum logic [2:0] {IDLE, CHECK, EXP_PUB, EXP_KEY, DONE} state_t;
endpackage

// File: rtl/dh_responder_if.sv
// dh_responder_if: peer, operand and result handshake bundle for dh_responder
interface dh_responder_if #(parameter int W = dh_pkg::DEF_W);
  logic [W-1:0] p, g, y, peer_r, pub, key;
  logic peer_valid, peer_ready, out_valid, out_ready, err, busy;
  modport master (output p, g, y, peer_valid, peer_r, out_ready,
                  input peer_ready, out_valid, pub, key, err, busy);
  modport slave (input p, g, y, peer_valid, peer_r, out_ready,
                 output peer_ready, out_valid, pub, key, err, busy);
endinterface

// File: rtl/mod_exp_seq.sv
// mod_exp_seq: LSB-first square-and-multiply, one exponent bit per cycle
module mod_exp_seq import dh_pkg::*; #(parameter int W = DEF_W) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exponent,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] result,
  output logic         done
);
  localparam int CW = $clog2(W) + 1;
  logic [W-1:0] acc, b, e;
  logic [CW-1:0] cnt;
  logic run;
  logic [2*W-1:0] am, bm;
  always_comb begin
    am = ({{W{1'b0}}, acc} * {{W{1'b0}}, b}) % {{W{1'b0}}, modulus};
    bm = ({{W{1'b0}}, b} * {{W{1'b0}}, b}) % {{W{1'b0}}, modulus};
  end
  assign result = acc;
  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      b <= '0;
      e <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc <= (modulus == W'(ONE)) ? '0 : W'(ONE);
        b <= base;
        e <= exponent;
        cnt <= CW'(W);
        run <= 1'b1;
      end else if (run) begin
        if (e[0]) acc <= am[W-1:0];
        b <= bm[W-1:0];
        e <= e >> 1;
        cnt <= cnt - 1'b1;
        // last iteration: done shows up the cycle after
        if (cnt == CW'(1)) begin
          run <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dh_responder.sv
// dh_responder: accepts R1, returns R2 = g^y mod p and K = R1^y mod p
module dh_responder import dh_pkg::*; #(parameter int W = DEF_W) (
  input logic clk,
  input logic rst,
  dh_responder_if.slave bus
);
  state_t state;
  logic [W-1:0] p_r, g_r, y_r, r_r, eng_base, eng_res;
  logic bad, eng_start, eng_done;
  assign bad = (p_r < W'(2)) || (r_r == '0) || (r_r >= p_r);
  assign eng_start = (state == CHECK && !bad) || (state == EXP_PUB && eng_done);
  assign eng_base = (state == CHECK) ? g_r % p_r : r_r;
  assign bus.peer_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  mod_exp_seq #(.W(W)) u_exp (
    .clk(clk), .rst(rst), .start(eng_start), .base(eng_base), .exponent(y_r),
    .modulus(p_r), .result(eng_res), .done(eng_done)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
      bus.pub <= '0;
      bus.key <= '0;
      p_r <= '0;
      g_r <= '0;
      y_r <= '0;
      r_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.peer_valid) begin
          p_r <= bus.p;
          g_r <= bus.g;
          y_r <= bus.y;
          r_r <= bus.peer_r;
          bus.pub <= '0;
          bus.key <= '0;
          bus.err <= 1'b0;
          state <= CHECK;
        end
        CHECK: if (bad) begin
          bus.err <= 1'b1;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end else state <= EXP_PUB;
        EXP_PUB: if (eng_done) begin
          bus.pub <= eng_res;
          state <= EXP_KEY;
        end
        EXP_KEY: if (eng_done) begin
          bus.key <= eng_res;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dh_responder.sv
// tb_dh_responder: directed scoreboard bench for dh_responder
module tb_dh_responder;
  typedef struct {logic [31:0] pub; logic [31:0] key; logic err;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  res_t sb[$];
  dh_responder_if #(.W(32)) b ();
  dh_responder dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;

  function automatic logic [31:0] mexp(input logic [31:0] bs, input logic [31:0] e, input logic [31:0] m);
    longint unsigned a, x;
    a = 64'd1 % m;
    x = bs % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) a = (a * x) % m;
      x = (x * x) % m;
    end
    return a[31:0];
  endfunction

  function automatic res_t model(input logic [31:0] p, input logic [31:0] g, input logic [31:0] y, input logic [31:0] r);
    res_t t;
    t.err = (p < 2) || (r == 0) || (r >= p);
    t.pub = t.err ? 32'd0 : mexp(g, y, p);
    t.key = t.err ? 32'd0 : mexp(r, y, p);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    res_t t;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      t = sb.pop_front();
      chk({tag, "_pub"}, b.pub, t.pub);
      chk({tag, "_key"}, b.key, t.key);
      chk({tag, "_err"}, 32'(b.err), 32'(t.err));
    end
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n;
    n = 1;
    while (!b.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
  endtask

  task automatic xchg(input string tag, input logic [31:0] p, input logic [31:0] g,
                      input logic [31:0] y, input logic [31:0] r, input int lat, input int hold);
    @(negedge clk);
    b.p = p; b.g = g; b.y = y; b.peer_r = r; b.peer_valid = 1'b1;
    chk({tag, "_acc_rdy"}, 32'(b.peer_ready), 1);
    sb.push_back(model(p, g, y, r));
    @(negedge clk);
    b.peer_valid = 1'b0;
    b.p = 32'd7; b.g = 32'd3; b.y = 32'hffff_ffff;
    wait_out(tag, lat);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_pub"}, b.pub, sb[0].pub);
      chk({tag, "_hold_key"}, b.key, sb[0].key);
      chk({tag, "_hold_ov"}, 32'(b.out_valid), 1);
      chk({tag, "_hold_prdy"}, 32'(b.peer_ready), 0);
      if (i == 3) b.peer_valid = 1'b1;
      @(negedge clk);
      b.peer_valid = 1'b0;
    end
    b.out_ready = 1'b1;
    check_out(tag);
    @(negedge clk);
    b.out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(b.peer_ready), 1);
    chk({tag, "_ov_clr"}, 32'(b.out_valid), 0);
    chk({tag, "_busy"}, 32'(b.busy), 0);
  endtask

  initial begin
    b.p = '0; b.g = '0; b.y = '0; b.peer_r = '0; b.peer_valid = 1'b0; b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(b.out_valid), 0);
    chk("rst_pub", b.pub, 0);
    chk("rst_key", b.key, 0);
    chk("rst_err", 32'(b.err), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_prdy", 32'(b.peer_ready), 1);
    rst = 1'b1;
    chk("model_nom_pub", model(23, 5, 15, 8).pub, 19);
    chk("model_nom_key", model(23, 5, 15, 8).key, 2);
    xchg("nom", 23, 5, 15, 8, 68, 0);
    xchg("bp", 23, 5, 15, 8, 68, 10);
    xchg("bad_eq", 23, 5, 15, 23, 2, 0);
    xchg("bad_zero", 23, 5, 15, 0, 2, 0);
    xchg("bad_p1", 1, 5, 15, 8, 2, 0);
    xchg("y0", 23, 5, 0, 8, 68, 0);
    xchg("ymsb", 23, 5, 32'h8000_0001, 8, 68, 0);
    xchg("gbig", 23, 28, 15, 8, 68, 0);
    xchg("gzero", 23, 46, 15, 8, 68, 0);
    xchg("bigp", 32'hffff_fffb, 32'h1234_5678, 32'hdead_beef, 32'h0bad_cafe, 68, 2);
    // reset in cycle 40 of an exchange
    @(negedge clk);
    b.p = 23; b.g = 5; b.y = 15; b.peer_r = 8; b.peer_valid = 1'b1;
    @(negedge clk);
    b.peer_valid = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_ov", 32'(b.out_valid), 0);
    chk("mrst_pub", b.pub, 0);
    chk("mrst_key", b.key, 0);
    chk("mrst_prdy", 32'(b.peer_ready), 1);
    xchg("post_rst", 23, 5, 15, 8, 68, 0);
    // back-to-back with peer_valid held high
    @(negedge clk);
    b.p = 23; b.g = 5; b.y = 15; b.peer_r = 8; b.peer_valid = 1'b1;
    sb.push_back(model(23, 5, 15, 8));
    @(negedge clk);
    b.p = 29; b.g = 2; b.y = 10; b.peer_r = 3;
    wait_out("b2b1", 68);
    b.out_ready = 1'b1;
    chk("b2b_hs_prdy", 32'(b.peer_ready), 0);
    check_out("b2b1");
    @(negedge clk);
    b.out_ready = 1'b0;
    chk("b2b_acc2_rdy", 32'(b.peer_ready), 1);
    sb.push_back(model(29, 2, 10, 3));
    @(negedge clk);
    b.peer_valid = 1'b0;
    chk("b2b_busy2", 32'(b.busy), 1);
    wait_out("b2b2", 68);
    b.out_ready = 1'b1;
    check_out("b2b2");
    @(negedge clk);
    b.out_ready = 1'b0;
    chk("b2b_end_ov", 32'(b.out_valid), 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
